// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the data memory with integrated hardware stack.
// Holds the operation encoding, the per-cycle priority decode and default widths.
package data_memory_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 5;
    localparam int DEF_STACK_DEPTH = 8;

    typedef enum logic [2:0] {
        OP_IDLE  = 3'd0,
        OP_READ  = 3'd1,
        OP_WRITE = 3'd2,
        OP_PUSH  = 3'd3,
        OP_POP   = 3'd4,
        OP_SWAP  = 3'd5
    } mem_op_t;

    // Priority: swap, push, pop, write, read; a swap on an empty stack degrades to a push
    function automatic mem_op_t decode_op(
        input logic push,
        input logic pop,
        input logic wr,
        input logic rd,
        input logic empty
    );
        mem_op_t op;
        if (push && pop && !empty) begin
            op = OP_SWAP;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end else if (wr) begin
            op = OP_WRITE;
        end else if (rd) begin
            op = OP_READ;
        end else begin
            op = OP_IDLE;
        end
        return op;
    endfunction

endpackage

// File: rtl/stack_pointer_ctrl.sv
// Stack bookkeeping: occupancy count, full/empty decode, sticky error flags
// and the push/top word addresses for a stack growing down from the top of memory.
module stack_pointer_ctrl
    import data_memory_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int CNT_WIDTH   = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  mem_op_t               i_op,
    output logic [CNT_WIDTH-1:0]  o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow,
    output logic                  o_underflow,
    output logic [ADDR_WIDTH-1:0] o_push_addr,
    output logic [ADDR_WIDTH-1:0] o_top_addr
);

    localparam logic [CNT_WIDTH-1:0]  FULL_CNT = CNT_WIDTH'(STACK_DEPTH);
    localparam logic [CNT_WIDTH-1:0]  ONE_CNT  = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR = ADDR_WIDTH'(1);

    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [ADDR_WIDTH-1:0] w_cnt_addr;

    assign w_cnt_addr = ADDR_WIDTH'(r_count);

    // DEPTH-1-count is the bitwise complement in ADDR_WIDTH bits; top sits one word above
    assign o_push_addr = ~w_cnt_addr;
    assign o_top_addr  = ~w_cnt_addr + ONE_ADDR;

    assign o_count     = r_count;
    assign o_full      = (r_count == FULL_CNT);
    assign o_empty     = (r_count == '0);
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

    // Count update and sticky error capture
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (i_op)
                OP_PUSH: begin
                    if (o_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_count <= r_count + ONE_CNT;
                    end
                end
                OP_POP: begin
                    if (o_empty) begin
                        r_underflow <= 1'b1;
                    end else begin
                        r_count <= r_count - ONE_CNT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/data_stack_memory.sv
// Word-addressed synchronous RAM with random access plus a hardware stack
// occupying the top STACK_DEPTH words; registered read/pop data output.
module data_stack_memory
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int CNT_WIDTH   = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  sig_enable_data_memory_write,
    input  logic                  sig_enable_data_memory_read,
    input  logic                  sig_push,
    input  logic                  sig_pop,
    output logic                  flag_full,
    output logic                  flag_empty,
    output logic                  flag_overflow,
    output logic                  flag_underflow,
    output logic [CNT_WIDTH-1:0]  stack_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
    mem_op_t               w_op;
    logic [ADDR_WIDTH-1:0] w_push_addr;
    logic [ADDR_WIDTH-1:0] w_top_addr;

    assign w_op = decode_op(sig_push, sig_pop, sig_enable_data_memory_write,
                            sig_enable_data_memory_read, flag_empty);

    stack_pointer_ctrl #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STACK_DEPTH (STACK_DEPTH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_stack_pointer_ctrl (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_op        (w_op),
        .o_count     (stack_count),
        .o_full      (flag_full),
        .o_empty     (flag_empty),
        .o_overflow  (flag_overflow),
        .o_underflow (flag_underflow),
        .o_push_addr (w_push_addr),
        .o_top_addr  (w_top_addr)
    );

    // RAM write port; contents are deliberately left untouched by reset
    always_ff @(posedge clock) begin
        if (reset_n) begin
            case (w_op)
                OP_WRITE: r_mem[address] <= data_in;
                OP_PUSH: begin
                    if (!flag_full) begin
                        r_mem[w_push_addr] <= data_in;
                    end
                end
                OP_SWAP:  r_mem[w_top_addr] <= data_in;
                default: begin
                end
            endcase
        end
    end

    // Registered read/pop/swap data with a one-cycle valid pulse
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            case (w_op)
                OP_READ: begin
                    r_data_out   <= r_mem[address];
                    r_data_valid <= 1'b1;
                end
                OP_POP: begin
                    if (!flag_empty) begin
                        r_data_out   <= r_mem[w_top_addr];
                        r_data_valid <= 1'b1;
                    end
                end
                OP_SWAP: begin
                    r_data_out   <= r_mem[w_top_addr];
                    r_data_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;

endmodule

// File: doc/data_stack_memory.md
Name: data_stack_memory

Overview:
Parametrised successor to the data memory. Provides a word-addressed synchronous RAM with random-access read and write. The top STACK_DEPTH words form a hardware stack with push, pop and swap, a live occupancy count, full/empty flags and sticky overflow/underflow error flags. It sits on the datapath's data-memory bus, and the control unit drives the enables directly.

Parameters:
DATA_WIDTH, 32, word width in bits
ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH words
STACK_DEPTH, 8, words reserved for the stack at the top of memory; legal range 1..DEPTH
CNT_WIDTH, $clog2(STACK_DEPTH+1), width of stack_count (derived, not overridden)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
address  in  ADDR_WIDTH  word address for random-access read/write; ignored for stack ops
data_in  in  DATA_WIDTH  write / push data
data_out  out  DATA_WIDTH  registered read / pop data
data_valid  out  1  one-cycle pulse: data_out updated by an accepted read, pop or swap
sig_enable_data_memory_write  in  1  random-access write
sig_enable_data_memory_read  in  1  random-access read
sig_push  in  1  push data_in
sig_pop  in  1  pop top of stack
flag_full  out  1  stack_count == STACK_DEPTH
flag_empty  out  1  stack_count == 0
flag_overflow  out  1  sticky: push attempted while full
flag_underflow  out  1  sticky: pop attempted while empty
stack_count  out  CNT_WIDTH  current stack occupancy

Behaviour:
- Reset (reset_n low at a rising edge): data_out=0, data_valid=0, stack_count=0, flag_empty=1, flag_full=0, flag_overflow=0, flag_underflow=0. RAM contents are not cleared.
- Reset asserted mid-operation: the operation in that cycle is discarded. No RAM write and no count change.
- Operation decode per cycle, in priority order: SWAP, PUSH, POP, WRITE, READ, IDLE.
- Stack ops (push/pop) always win over the RAM enables. The losing RAM op is dropped silently and raises no flag.
- SWAP (push and pop together, count>0):
  - data_out <= mem[top], then mem[top] <= data_in, on the same edge.
  - Count unchanged. data_valid=1 next cycle.
- SWAP with count==0: treated as PUSH. No underflow is raised.
- Stack layout: the stack grows downward from DEPTH-1. Push target is DEPTH-1-count. Top element is DEPTH-count.
- PUSH with count<STACK_DEPTH: mem[DEPTH-1-count] <= data_in; count+1.
- PUSH with count==STACK_DEPTH: no write, count unchanged, flag_overflow <= 1.
- POP with count>0: data_out <= mem[DEPTH-count]; count-1; data_valid=1 next cycle.
- POP with count==0: data_out holds its value, data_valid=0, flag_underflow <= 1.
- WRITE: mem[address] <= data_in. No output change.
- READ: data_out <= mem[address]; data_valid=1 next cycle. Latency is 1 clock.
- WRITE and READ asserted together: WRITE wins. No read-during-write forwarding is needed.
- Random access into the stack region is legal and aliases stack data. Intended for debug and inspection.
- data_out holds its last value when no read, pop or swap is accepted.
- flag_full and flag_empty are combinational decodes of the registered count. They are valid in the cycle after the op.
- Sticky error flags clear only on reset.

Decomposition:
- Shared package data_memory_pkg holds:
  - enum mem_op_t {OP_IDLE, OP_READ, OP_WRITE, OP_PUSH, OP_POP, OP_SWAP}
  - the priority decode function
  - the default width constants
- One sub-module, stack_pointer_ctrl. It owns stack_count, full/empty, overflow/underflow and push/top address generation.
- The top level owns the RAM array, op decode and the data_out register.

Test Plan:
1. Write 32 to address 1, then read address 1 -> data_out=32, data_valid pulses exactly 1 cycle after the read; address 1 before any write is don't-care.
2. Push 16,64,32,1,2,3, then pop 6 times:
   - stack_count goes 6..0.
   - data_out sequence is 3,2,1,32,64,16.
   - flag_empty=1 at the end.
3. Pop on empty -> flag_underflow=1, data_out still 16, data_valid=0, count stays 0.
4. Push 8 values (0x10..0x17) -> flag_full=1 after the 8th push. A 9th push of 0xFF -> flag_overflow=1, count=8, pop returns 0x17.
5. Swap and priority checks:
   - With stack [5], assert push+pop with data_in=9 -> data_out=5, count=1, next pop returns 9.
   - Push plus write to address 2 in the same cycle -> address 2 unchanged.
6. Reset mid-sequence:
   - Push 3 values, assert reset_n=0 during a push -> count=0, flags cleared, data_out=0.
   - Then read address 31 -> returns the first value pushed before reset (RAM is not cleared).
